// File: rtl/vga_clk_div_gen_pkg.sv
// Shared constants for the VGA pixel clock divider and the timing generator that consumes it.
package vga_clk_div_gen_pkg;

  localparam int unsigned DIV_MIN         = 2;
  localparam int unsigned CNT_W_DEFAULT   = 8;
  localparam int unsigned DIV_RST_DEFAULT = 4;

endpackage

// File: rtl/vga_clk_div_gen.sv
// Runtime-programmable integer clock divider: registered ~50% duty clock plus a period-start tick.
// A new divisor is staged and applied only when the phase counter wraps.
module vga_clk_div_gen
  import vga_clk_div_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned DIV_RST = DIV_RST_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] div_o,
  output logic             div_pend_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] staged_q;
  logic             pend_q;
  logic             clk_q;
  logic             tick_q;

  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] div_next;
  logic             wrap;
  logic [CNT_W:0]   hi_len;

  // hi_len is one bit wider so ceil(D/2) cannot overflow at the largest divisor.
  always_comb begin
    div_clamped = (div_i < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_i;
    wrap        = (cnt_q == (div_q - CNT_W'(1)));
    cnt_next    = wrap ? '0 : (cnt_q + CNT_W'(1));
    div_next    = div_q;
    if (wrap) begin
      if (div_load_i) begin
        div_next = div_clamped;
      end else if (pend_q) begin
        div_next = staged_q;
      end
    end
    hi_len = ({1'b0, div_next} + (CNT_W+1)'(1)) >> 1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      div_q    <= CNT_W'(DIV_RST);
      staged_q <= '0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      if (div_load_i) begin
        staged_q <= div_clamped;
      end
      if (en_i) begin
        cnt_q  <= cnt_next;
        div_q  <= div_next;
        clk_q  <= ({1'b0, cnt_next} < hi_len);
        tick_q <= wrap;
        pend_q <= wrap ? 1'b0 : (pend_q | div_load_i);
      end else begin
        tick_q <= 1'b0;
        pend_q <= pend_q | div_load_i;
      end
    end
  end

  assign clk_o      = clk_q;
  assign tick_o     = tick_q;
  assign cnt_o      = cnt_q;
  assign div_o      = div_q;
  assign div_pend_o = pend_q;

endmodule

// File: tb/tb_vga_clk_div_gen.sv
// Directed self-checking bench for vga_clk_div_gen: reset, divisor switching, clamp, enable stall,
// asynchronous reset with pending load, and the widest divisor.
module tb_vga_clk_div_gen;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  logic             div_pend;

  int vectors    = 0;
  int miscompares = 0;

  vga_clk_div_gen #(.CNT_W(CNT_W), .DIV_RST(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .div_i      (div_in),
    .div_load_i (div_load),
    .clk_o      (clk_out),
    .tick_o     (tick),
    .cnt_o      (cnt),
    .div_o      (div_cur),
    .div_pend_o (div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input int e_cnt, input int e_clk,
                               input int e_tick, input int e_div, input int e_pend);
    check_value({tag, " cnt"},  int'(cnt),      e_cnt);
    check_value({tag, " clk"},  int'(clk_out),  e_clk);
    check_value({tag, " tick"}, int'(tick),     e_tick);
    check_value({tag, " div"},  int'(div_cur),  e_div);
    check_value({tag, " pend"}, int'(div_pend), e_pend);
  endtask

  initial begin
    int since_tick;
    int hi_count;
    int max_cnt;
    int period;
    bit found;

    rst      = 1'b1;
    en       = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    #12;
    check_outputs("reset", 0, 1, 0, 4, 0);

    // D=4 out of reset: clk 1,1,0,0 and first tick four edges after release
    en = 1'b1;
    #2 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step_clock();
      check_outputs($sformatf("d4 edge%0d", k), k % 4, ((k % 4) < 2) ? 1 : 0,
                    ((k % 4) == 0) ? 1 : 0, 4, 0);
    end

    // Load 5 at cnt=1; must wait for the boundary
    step_clock();
    check_outputs("pre-load5", 1, 1, 0, 4, 0);
    div_in = 8'd5; div_load = 1'b1;
    step_clock();
    div_load = 1'b0;
    check_outputs("load5 staged", 2, 0, 0, 4, 1);
    step_clock();
    check_outputs("load5 wait", 3, 0, 0, 4, 1);
    step_clock();
    check_outputs("load5 applied", 0, 1, 1, 5, 0);
    for (int j = 1; j <= 10; j++) begin
      step_clock();
      check_outputs($sformatf("d5 edge%0d", j), j % 5, ((j % 5) < 3) ? 1 : 0,
                    ((j % 5) == 0) ? 1 : 0, 5, 0);
    end

    // Load 0 in the wrap cycle: clamped to 2 and bypassed without pending
    repeat (4) step_clock();
    check_outputs("pre-load0", 4, 0, 0, 5, 0);
    div_in = 8'd0; div_load = 1'b1;
    step_clock();
    div_load = 1'b0;
    check_outputs("load0 bypass", 0, 1, 1, 2, 0);
    for (int j = 1; j <= 4; j++) begin
      step_clock();
      check_outputs($sformatf("d2 edge%0d", j), j % 2, ((j % 2) == 0) ? 1 : 0,
                    ((j % 2) == 0) ? 1 : 0, 2, 0);
    end

    // Back to D=4, then stall three cycles at cnt=2
    div_in = 8'd4; div_load = 1'b1;
    step_clock();
    div_load = 1'b0;
    check_outputs("load4 staged", 1, 0, 0, 2, 1);
    step_clock();
    check_outputs("load4 applied", 0, 1, 1, 4, 0);
    since_tick = 0;
    step_clock(); since_tick++;
    step_clock(); since_tick++;
    check_outputs("pre-stall", 2, 0, 0, 4, 0);
    en = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step_clock(); since_tick++;
      check_outputs($sformatf("stall%0d", j), 2, 0, 0, 4, 0);
    end
    en = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 10 && !found; j++) begin
      step_clock(); since_tick++;
      if (tick) found = 1'b1;
    end
    check_value("stall tick found", int'(found), 1);
    check_value("stall tick spacing", since_tick, 7);
    check_outputs("post-stall", 0, 1, 1, 4, 0);

    // Asynchronous reset between edges with a load pending
    step_clock();
    step_clock();
    div_in = 8'd9; div_load = 1'b1;
    step_clock();
    div_load = 1'b0;
    check_outputs("pend before rst", 3, 0, 0, 4, 1);
    #2 rst = 1'b1;
    #1;
    check_outputs("async rst", 0, 1, 0, 4, 0);
    step_clock();
    check_outputs("held rst", 0, 1, 0, 4, 0);
    #3 rst = 1'b0;
    repeat (3) step_clock();
    check_outputs("after rst 3", 3, 0, 0, 4, 0);
    step_clock();
    check_outputs("after rst 4", 0, 1, 1, 4, 0);

    // Widest divisor: 255 -> high 128, low 127
    div_in = 8'd255; div_load = 1'b1;
    step_clock();
    div_load = 1'b0;
    check_outputs("load255 staged", 1, 1, 0, 4, 1);
    found = 1'b0;
    for (int j = 0; j < 10 && !found; j++) begin
      step_clock();
      if (tick) found = 1'b1;
    end
    check_value("d255 start found", int'(found), 1);
    check_outputs("d255 start", 0, 1, 1, 255, 0);
    hi_count = 1;
    max_cnt  = 0;
    period   = 0;
    found    = 1'b0;
    for (int j = 0; j < 600 && !found; j++) begin
      step_clock();
      period++;
      if (tick) begin
        found = 1'b1;
      end else begin
        if (clk_out) hi_count++;
        if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      end
    end
    check_value("d255 tick found", int'(found), 1);
    check_value("d255 period", period, 255);
    check_value("d255 high cycles", hi_count, 128);
    check_value("d255 max cnt", max_cnt, 254);
    check_outputs("d255 wrap", 0, 1, 1, 255, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
